my_rx_fifo: RTL and testbench
=============================

Name: my_rx_fifo

Overview:
- Receive byte buffer directly downstream of the RX UART; consumes its 1-cycle `valid`/`rx_data`/`error` outputs.
- Stores received bytes in a circular FIFO and presents them on a valid/ready stream to the host logic (CPU bus bridge, command parser).
- Tracks fill level, almost-full, sticky overrun and sticky framing-error status.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- ALMOST_FULL_LEVEL, 12, almost_full asserted when level >= this value; range 1..DEPTH.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  1-cycle pulse: in_data holds a received byte.
- in_data  input  8  received byte.
- in_error  input  1  1-cycle pulse: stop-bit framing error (no byte delivered).
- out_valid  output  1  head byte available.
- out_ready  input  1  consumer accepts head byte.
- out_data  output  8  head byte; 8'h00 whenever out_valid=0.
- level  output  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH.
- almost_full  output  1  level >= ALMOST_FULL_LEVEL.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: in_error seen.
- clear_flags  input  1  clears overrun and frame_err.

Behaviour:
- Reset (resetn low, asynchronous): read/write pointers = 0, level = 0, out_valid = 0, out_data = 0, almost_full = 0, overrun = 0, frame_err = 0. Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits wide with a wrap bit. Empty when pointers are equal; full when the index bits are equal and the wrap bits differ. Index wraps DEPTH-1 -> 0 naturally.
- Push: in_valid=1 and (not full, or pop in the same cycle). Writes in_data at wr_ptr; wr_ptr+1.
- Pop: out_valid=1 and out_ready=1. rd_ptr+1.
- out_valid = not empty. out_data = mem[rd_ptr] (combinational read), forced to 0 when empty.
- Latency: a byte pushed at edge N is visible on out_valid/out_data after edge N (the cycle following the in_valid cycle). There is no bypass path while empty.
- Simultaneous push and pop:
  - When full: both are accepted, level stays DEPTH, no overrun.
  - When empty: only the push occurs, because out_valid=0.
- Overflow: in_valid while full with no pop -> byte discarded, pointers unchanged, overrun set at the next edge.
- out_ready while empty is ignored.
- level updates as: +1 on push only, -1 on pop only, unchanged on both or neither. Registered, with the same timing as the pointers. almost_full is derived from the registered level.
- frame_err is set on in_error=1. in_error and in_valid are never asserted together by the UART. If they are, both actions occur.
- clear_flags clears overrun and frame_err at the next edge. If a set event occurs in the same cycle, set wins.
- Reset mid-operation discards all contents. It is asynchronous, so outputs go to their reset values immediately, without waiting for a clock edge.
- A read while in_valid, out_ready and clear_flags are all asserted in one cycle obeys all of the rules above independently.

Optional Feature:
- Macro: MY_RX_FIFO_ERRCNT_EN.
- With the macro defined:
  - Adds output port err_count [7:0]: an 8-bit saturating counter incremented on each in_error pulse and on each dropped (overrun) byte, saturating at 255.
  - Two increments requested in the same cycle add 2, still saturating.
  - clear_flags resets it to 0, but an increment in the same cycle wins and the result is 1 or 2.
  - Reset value is 0.
- Without the macro: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: all outputs 0, out_valid=0, level=0 for 10 cycles. Assert resetn low mid-burst: level -> 0 and out_valid -> 0 without a clock edge.
- Push 0xA5, 0x3C with out_ready=0 -> level=2, out_data=0xA5. Pulse out_ready for one cycle -> out_data=0x3C, level=1. Second pop -> out_valid=0, out_data=0x00.
- Push 16 bytes 0x00..0x0F -> level=16; almost_full asserted from the 12th push onward. Push 0xFF -> dropped, overrun=1. Drain -> 0x00..0x0F in order, no 0xFF.
- Full FIFO with out_ready=1 held plus push 0x77 in the same cycle -> level stays 16, overrun stays 0, 0x77 emerges last.
- Pulse in_error -> frame_err=1 and stays set. clear_flags together with a new in_error -> frame_err remains 1. clear_flags alone -> 0. With MY_RX_FIFO_ERRCNT_EN: 300 in_error pulses -> err_count=255.
- Wrap-around: run 40 push/pop cycles at random interleaving with out_ready=1 at 50% -> output byte order matches a scoreboard, and level is never negative or above 16.

Source files
------------

// File: rtl/my_rx_fifo.sv
// -----------------------------------------------------------------------------
// my_rx_fifo
// Receive byte buffer that sits directly behind the RX UART. Bytes arriving as
// single-cycle in_valid pulses are stored in a circular FIFO and offered to the
// host on a valid/ready stream. The block also reports the fill level,
// almost-full, a sticky overrun flag and a sticky framing-error flag.
//
// Optional build macro: MY_RX_FIFO_ERRCNT_EN
//   Adds err_count, an 8-bit saturating count of in_error pulses and dropped
//   bytes.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   in_valid     1-cycle pulse, in_data holds a received byte
//   in_data      received byte
//   in_error     1-cycle pulse, stop-bit framing error (no byte delivered)
//   out_valid    head byte available (combinational, FIFO not empty)
//   out_ready    consumer accepts the head byte
//   out_data     head byte, 8'h00 whenever out_valid is low (combinational)
//   level        number of stored bytes, 0..DEPTH
//   almost_full  level >= ALMOST_FULL_LEVEL
//   overrun      sticky, a byte was dropped because the FIFO was full
//   frame_err    sticky, in_error was seen
//   clear_flags  clears overrun, frame_err (and err_count when enabled)
//   err_count    saturating error counter (MY_RX_FIFO_ERRCNT_EN only)
// -----------------------------------------------------------------------------
module my_rx_fifo #(
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic                       in_error,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       clear_flags
`ifdef MY_RX_FIFO_ERRCNT_EN
  ,
  output logic [7:0]                 err_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Storage and pointers (pointers carry one extra wrap bit)
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_almost_full;
  logic          r_overrun;
  logic          r_frame_err;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_level_nxt;

  // Empty/full decode from the wrap-bit pointers
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when the consumer takes the head byte.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  // Next fill level
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + PW'(1);
      2'b01:   w_level_nxt = r_level - PW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Byte storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Pointers, level and almost-full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level       <= w_level_nxt;
      r_almost_full <= (32'(w_level_nxt) >= ALMOST_FULL_LEVEL);
    end
  end

  // Sticky status flags; a set event in the clear cycle wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_flags) begin
        r_overrun <= 1'b0;
      end
      if (in_error) begin
        r_frame_err <= 1'b1;
      end else if (clear_flags) begin
        r_frame_err <= 1'b0;
      end
    end
  end

`ifdef MY_RX_FIFO_ERRCNT_EN
  logic [7:0] r_err_count;
  logic [1:0] w_inc;
  logic [8:0] w_sum;
  logic [7:0] w_err_count_nxt;

  // Up to two increments per cycle (framing error plus dropped byte)
  assign w_inc = 2'(in_error) + 2'(w_drop);
  assign w_sum = 9'(r_err_count) + 9'(w_inc);

  // Saturating count; clear with a simultaneous increment yields the increment
  always_comb begin
    w_err_count_nxt = r_err_count;
    if (clear_flags) begin
      w_err_count_nxt = 8'(w_inc);
    end else if (w_sum > 9'd255) begin
      w_err_count_nxt = 8'd255;
    end else begin
      w_err_count_nxt = w_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_count <= 8'd0;
    end else begin
      r_err_count <= w_err_count_nxt;
    end
  end

  assign err_count = r_err_count;
`endif

  // Output stream: combinational head read, zeroed while empty
  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign level       = r_level;
  assign almost_full = r_almost_full;
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_my_rx_fifo.sv
module tb_my_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_error;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overrun;
  logic          frame_err;
  logic          clear_flags;
`ifdef MY_RX_FIFO_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  int checks = 0;
  int errors = 0;

  my_rx_fifo #(.DEPTH(16), .ALMOST_FULL_LEVEL(12)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_error    (in_error),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clear_flags (clear_flags)
`ifdef MY_RX_FIFO_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 time unit after the edge with
  // all pulse inputs back to idle.
  task automatic cyc(input logic v, input logic [7:0] d, input logic e,
                     input logic r, input logic c);
    in_valid    = v;
    in_data     = d;
    in_error    = e;
    out_ready   = r;
    clear_flags = c;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_error    = 1'b0;
    out_ready   = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      obs = {out_valid, out_data, level};
      checks++;
      if (obs !== 14'd0 || almost_full !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: valid/data/level=%h af=%b ovr=%b fe=%b, required all 0",
                 i, obs, almost_full, overrun, frame_err);
      end
    end
    // Asynchronous reset in the middle of a burst
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL burst_level: got %0d, required 3", level);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: level=%0d valid=%b data=%h, required 0/0/00",
               level, out_valid, out_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL first_latency: valid=%b data=%h, required 1/a5", out_valid, out_data);
    end
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd2 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL two_pushed: level=%0d data=%h, required 2/a5", level, out_data);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd1 || out_data !== 8'h3C || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_pop: level=%0d data=%h valid=%b, required 1/3c/1",
               level, out_data, out_valid);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd0 || out_data !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL second_pop: level=%0d data=%h valid=%b, required 0/00/0",
               level, out_data, out_valid);
    end
    // out_ready while empty is ignored
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty: level=%0d valid=%b, required 0/0", level, out_valid);
    end
    // Push and pop while empty: only the push takes effect
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd1 || out_data !== 8'h5A) begin
      errors++;
      $display("FAIL pushpop_empty: level=%0d data=%h, required 1/5a", level, out_data);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 8'(k - 1), 1'b0, 1'b0, 1'b0);
      checks++;
      if (almost_full !== (k >= 12) || level !== 5'(k)) begin
        errors++;
        $display("FAIL fill_push %0d: af=%b level=%0d, required %b/%0d",
                 k, almost_full, level, (k >= 12), k);
      end
    end
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || level !== 5'd16 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow: ovr=%b level=%0d fe=%b, required 1/16/0", overrun, level, frame_err);
    end
`ifdef MY_RX_FIFO_ERRCNT_EN
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL errcnt_drop: got %0d, required 1", err_count);
    end
    // Dropped byte plus framing error in one cycle adds 2
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 8'd3 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL errcnt_double: cnt=%0d fe=%b, required 3/1", err_count, frame_err);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        errors++;
        $display("FAIL drain %0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, 8'(i));
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL drained: valid=%b level=%0d af=%b, required 0/0/0", out_valid, level, almost_full);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_after_full: ovr=%b fe=%b, required 0/0", overrun, frame_err);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL full_pushpop: level=%0d ovr=%b data=%h, required 16/0/11", level, overrun, out_data);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'h77 : 8'(8'h11 + i);
      checks++;
      if (out_data !== exp) begin
        errors++;
        $display("FAIL full_pushpop_drain %0d: got %h, required %h", i, out_data, exp);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_frame_err();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_sticky: got %b, required 1", frame_err);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_set_wins: got %b, required 1", frame_err);
    end
`ifdef MY_RX_FIFO_ERRCNT_EN
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL errcnt_clear_inc: got %0d, required 1", err_count);
    end
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear: got %b, required 0", frame_err);
    end
    // Byte and error together: both actions occur
    cyc(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || level !== 5'd1 || out_data !== 8'h9C) begin
      errors++;
      $display("FAIL byte_and_error: fe=%b level=%0d data=%h, required 1/1/9c", frame_err, level, out_data);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
`ifdef MY_RX_FIFO_ERRCNT_EN
    for (int i = 0; i < 300; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL errcnt_saturate: got %0d, required 255", err_count);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic       v;
    logic       r;
    logic [7:0] d;
    logic       pop;
    logic [7:0] exp;
    void'($urandom(32'h1234));
    for (int i = 0; i < 40; i++) begin
      v   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      exp = (q.size() > 0) ? q[0] : 8'h00;
      checks++;
      if (out_valid !== (q.size() > 0) || out_data !== exp) begin
        errors++;
        $display("FAIL wrap_head %0d: valid=%b data=%h, required %b/%h",
                 i, out_valid, out_data, (q.size() > 0), exp);
      end
      pop = (q.size() > 0) && r;
      cyc(v, d, 1'b0, r, 1'b0);
      if (pop) void'(q.pop_front());
      if (v && q.size() < 16) q.push_back(d);
      checks++;
      if (level !== 5'(q.size()) || level > 5'd16) begin
        errors++;
        $display("FAIL wrap_level %0d: got %0d, required %0d", i, level, q.size());
      end
    end
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_error    = 1'b0;
    out_ready   = 1'b0;
    clear_flags = 1'b0;
    #12 resetn = 1'b1;
    test_reset();
    test_basic();
    test_full();
    test_full_pushpop();
    test_frame_err();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
